// File: rtl/linebuffer_fetch_pkg.sv
// rtl/linebuffer_fetch_pkg.sv - shared state encoding and width helper for the line fetcher
package linebuffer_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_FETCH = 2'd2
  } fetch_state_e;

  // Index width for a table of the given depth; never below 1 bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/linebuffer_fetch_if.sv
// rtl/linebuffer_fetch_if.sv - control and framebuffer-read bundle of the line fetcher
interface linebuffer_fetch_if #(
  parameter int SCALEW = 6,
  parameter int ADDRW  = 19
);
  logic              frame;
  logic              line_sys;
  logic [SCALEW-1:0] scale_v;
  logic              fb_re;
  logic [ADDRW-1:0]  fb_addr;
  logic              en_in;
  logic              busy;

  modport master (
    input  frame, line_sys, scale_v,
    output fb_re, fb_addr, en_in, busy
  );

  modport slave (
    output frame, line_sys, scale_v,
    input  fb_re, fb_addr, en_in, busy
  );
endinterface

// File: rtl/linebuffer_fetch_delay_pipe.sv
// rtl/linebuffer_fetch_delay_pipe.sv - generic delay line with async reset and sync clear
module delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, clr};
      assign dout      = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/linebuffer_fetch.sv
// rtl/linebuffer_fetch.sv - picks the source row per line and streams LEN framebuffer reads
module linebuffer_fetch
  import linebuffer_fetch_pkg::*;
#(
  parameter int LEN    = 640,
  parameter int HEIGHT = 480,
  parameter int SCALEW = 6,
  parameter int RD_LAT = 1,
  parameter int ADDRW  = $clog2(LEN*HEIGHT)
) (
  input  logic                clk_sys,
  input  logic                rst,
  linebuffer_fetch_if.master  bus
);

  localparam int COLW = addr_w(LEN);
  localparam int ROWW = addr_w(HEIGHT);

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] PREP  = 2'(ST_PREP);
  localparam logic [1:0] FETCH = 2'(ST_FETCH);

  localparam logic [COLW-1:0]  COL_LAST = COLW'(LEN - 1);
  localparam logic [ROWW-1:0]  ROW_LAST = ROWW'(HEIGHT - 1);
  localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(LEN);

  logic [1:0]        state;
  logic [SCALEW-1:0] cnt_v;
  logic [ROWW-1:0]   src_row;
  logic [ADDRW-1:0]  row_base;
  logic [COLW-1:0]   col;
  logic              first;
  logic              fb_re_q;
  logic [ADDRW-1:0]  fb_addr_q;
  logic              en_in_q;

  logic              first_eff, first_nx;
  logic [SCALEW-1:0] cnt_eff, cnt_nx, scale_last;
  logic [ROWW-1:0]   row_eff, row_nx;
  logic [ADDRW-1:0]  base_eff, base_nx;
  logic              push, pipe_out;

  // A frame pulse resets the row tracker before a coincident line pulse consumes it.
  always_comb begin
    first_eff  = bus.frame | first;
    cnt_eff    = bus.frame ? '0 : cnt_v;
    row_eff    = bus.frame ? '0 : src_row;
    base_eff   = bus.frame ? '0 : row_base;
    scale_last = (bus.scale_v == '0) ? '0 : bus.scale_v - SCALEW'(1);
    first_nx   = first_eff;
    cnt_nx     = cnt_eff;
    row_nx     = row_eff;
    base_nx    = base_eff;
    if (bus.line_sys) begin
      if (first_eff) begin
        first_nx = 1'b0;
      end else if (cnt_eff == scale_last) begin
        cnt_nx = '0;
        if (row_eff != ROW_LAST) begin
          row_nx  = row_eff + ROWW'(1);
          base_nx = base_eff + ROW_STEP;
        end
      end else begin
        cnt_nx = cnt_eff + SCALEW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      first    <= 1'b1;
      cnt_v    <= '0;
      src_row  <= '0;
      row_base <= '0;
    end else begin
      first    <= first_nx;
      cnt_v    <= cnt_nx;
      src_row  <= row_nx;
      row_base <= base_nx;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fb_re_q   <= 1'b0;
      fb_addr_q <= '0;
      col       <= '0;
    end else if (bus.line_sys) begin
      state   <= PREP;
      fb_re_q <= 1'b0;
      col     <= '0;
    end else begin
      case (state)
        PREP: begin
          state     <= FETCH;
          fb_re_q   <= 1'b1;
          fb_addr_q <= row_base;
          col       <= '0;
        end
        FETCH: begin
          fb_addr_q <= fb_addr_q + ADDRW'(1);
          col       <= col + COLW'(1);
          if (col == COL_LAST) begin
            fb_re_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          fb_re_q <= 1'b0;
        end
      endcase
    end
  end

  // The start marker rides RD_LAT-1 stages plus the en_in register, landing one cycle before pixel 0.
  assign push = (state == PREP) && !bus.line_sys;

  delay_pipe #(
    .WIDTH (1),
    .DEPTH (RD_LAT - 1)
  ) u_en_pipe (
    .clk  (clk_sys),
    .rst  (rst),
    .clr  (bus.line_sys),
    .din  (push),
    .dout (pipe_out)
  );

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) en_in_q <= 1'b0;
    else     en_in_q <= pipe_out & ~bus.line_sys;
  end

  assign bus.fb_re   = fb_re_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.en_in   = en_in_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_linebuffer_fetch.sv
// tb/tb_linebuffer_fetch.sv - directed and random checks of linebuffer_fetch against a line-level model
module tb_linebuffer_fetch;

  localparam int LEN    = 8;
  localparam int HEIGHT = 4;
  localparam int SCALEW = 6;
  localparam int RD_LAT = 2;
  localparam int ADDRW  = 5;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  linebuffer_fetch_if #(.SCALEW(SCALEW), .ADDRW(ADDRW)) bus();

  linebuffer_fetch #(
    .LEN(LEN), .HEIGHT(HEIGHT), .SCALEW(SCALEW), .RD_LAT(RD_LAT), .ADDRW(ADDRW)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Line-level model: the k-th line since frame start reads row min(HEIGHT-1, k/scale),
  // its burst occupies cycles start..start+LEN-1, and en_in fires RD_LAT-1 cycles in.
  int k      = 0;
  int start  = -100;
  int base   = 0;
  bit active = 0;

  int got_bases[$];
  int exp_bases[$];
  int en_cnt  = 0;
  bit prev_re = 0;

  task automatic tick(input bit f, input bit l);
    int eff, row, t;
    bit e_re;
    bus.frame    = f;
    bus.line_sys = l;
    @(posedge clk_sys);
    if (rst) begin
      k      = 0;
      active = 0;
    end else begin
      if (f) k = 0;
      if (l) begin
        eff = (bus.scale_v == 0) ? 1 : int'(bus.scale_v);
        row = k / eff;
        if (row > HEIGHT - 1) row = HEIGHT - 1;
        k++;
        base   = row * LEN;
        start  = cyc + 2;
        active = 1;
      end
    end
    cyc++;
    @(negedge clk_sys);
    t    = cyc;
    e_re = active && t >= start && t < start + LEN;
    check("fb_re", 32'(bus.fb_re), 32'(e_re));
    check("en_in", 32'(bus.en_in), 32'(active && t == start + RD_LAT - 1));
    check("busy",  32'(bus.busy),  32'(active && t >= start - 1 && t < start + LEN));
    if (e_re) check("fb_addr", 32'(bus.fb_addr), 32'(base + t - start));
    if (bus.fb_re && !prev_re) got_bases.push_back(int'(bus.fb_addr));
    if (bus.en_in) en_cnt++;
    prev_re      = bus.fb_re;
    bus.frame    = 1'b0;
    bus.line_sys = 1'b0;
  endtask

  task automatic check_bases(input string tag);
    check({tag, "_count"}, 32'(got_bases.size()), 32'(exp_bases.size()));
    for (int i = 0; i < exp_bases.size(); i++) begin
      if (i < got_bases.size()) check(tag, 32'(got_bases[i]), 32'(exp_bases[i]));
      else check(tag, 32'hFFFF, 32'(exp_bases[i]));
    end
    got_bases.delete();
  endtask

  task automatic run_lines(input int n, input int gap);
    got_bases.delete();
    tick(1, 0);
    tick(0, 0);
    for (int i = 0; i < n; i++) begin
      tick(0, 1);
      repeat (gap - 1) tick(0, 0);
    end
  endtask

  // Framebuffer (data = addr[3:0], RD_LAT=2) chained into a behavioural line buffer.
  logic [3:0] fb_d1 = '0;
  logic [3:0] fb_d2 = '0;
  int         wptr  = 0;
  int         wcnt  = 0;
  logic [3:0] lb_mem [LEN];

  always @(posedge clk_sys) begin
    fb_d1 <= bus.fb_addr[3:0];
    fb_d2 <= fb_d1;
    if (bus.line_sys) begin
      wcnt <= 0;
    end else if (bus.en_in) begin
      wcnt <= LEN;
      wptr <= 0;
    end else if (wcnt > 0) begin
      lb_mem[wptr] <= fb_d2;
      wptr         <= wptr + 1;
      wcnt         <= wcnt - 1;
    end
  end

  initial begin
    bus.frame    = 1'b0;
    bus.line_sys = 1'b0;
    bus.scale_v  = 6'd1;
    rst          = 1'b0;
    #1 rst = 1'b1;
    tick(0, 0);
    tick(0, 0);
    check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    rst = 1'b0;

    // First line after reset: row 0 lands in line buffer addresses 0..7.
    tick(1, 0);
    repeat (5) tick(0, 0);
    tick(0, 1);
    repeat (15) tick(0, 0);
    for (int i = 0; i < LEN; i++) check("lb_mem", 32'(lb_mem[i]), 32'(i));
    got_bases.delete();

    bus.scale_v = 6'd2;
    run_lines(5, 20);
    exp_bases = '{0, 0, 8, 8, 16};
    check_bases("bases_s2");

    bus.scale_v = 6'd1;
    run_lines(6, 20);
    exp_bases = '{0, 8, 16, 24, 24, 24};
    check_bases("bases_s1");

    bus.scale_v = 6'd0;
    run_lines(6, 20);
    exp_bases = '{0, 8, 16, 24, 24, 24};
    check_bases("bases_s0");

    // Abort on the third fb_re cycle of a burst.
    bus.scale_v = 6'd1;
    tick(1, 0);
    tick(0, 1);
    got_bases.delete();
    repeat (3) tick(0, 0);
    en_cnt = 0;
    tick(0, 1);
    repeat (20) tick(0, 0);
    exp_bases = '{0, 8};
    check_bases("abort_bases");
    check("abort_en_cnt", 32'(en_cnt), 32'd1);

    // Frame and line on the same edge mid-frame restart at row 0.
    tick(0, 1);
    repeat (12) tick(0, 0);
    got_bases.delete();
    tick(1, 1);
    repeat (12) tick(0, 0);
    exp_bases = '{0};
    check_bases("frame_line");

    // Reset mid-fetch takes effect without a clock edge.
    tick(0, 1);
    repeat (4) tick(0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_fb_re", 32'(bus.fb_re), 32'd0);
    check("arst_en_in", 32'(bus.en_in), 32'd0);
    check("arst_busy",  32'(bus.busy),  32'd0);
    tick(0, 0);
    rst = 1'b0;
    got_bases.delete();
    tick(1, 0);
    tick(0, 1);
    repeat (12) tick(0, 0);
    exp_bases = '{0};
    check_bases("post_rst");

    // Random lines, aborts and frames; scale only changes together with a frame.
    for (int i = 0; i < 1500; i++) begin
      bit f, l;
      f = ($urandom_range(0, 99) < 4);
      if (f) bus.scale_v = 6'($urandom_range(0, 3));
      l = ($urandom_range(0, 11) == 0) || (f && $urandom_range(0, 1) == 1);
      tick(f, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
